// File: rtl/slc3_mem_ctrl.sv
`timescale 1ns/1ps
// SLC-3 memory-side stage: turns the CPU's Mem_OE/Mem_WE strobes into timed SRAM cycles,
// reports completion on mem_ready and decodes one MMIO address (switches in, hex display out).
module slc3_mem_ctrl #(
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned WR_WAIT = 2,
  parameter logic [15:0] SW_ADDR = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_CE,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic        Mem_UB,
  input  logic        Mem_LB,
  input  logic [15:0] MAR,
  input  logic [15:0] data_to_mem,
  output logic [15:0] data_from_mem,
  output logic        mem_ready,
  input  logic [15:0] Switches,
  output logic [15:0] hex_out,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_wdata,
  input  logic [15:0] sram_rdata,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n,
  output logic        protocol_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_MMIO_RD,
    ST_RD_DONE,
    ST_WR_PULSE,
    ST_WR_HOLD
  } state_t;

  // Counters load with cycles-1 and the state exits when the count reaches zero.
  localparam logic [3:0] RD_LAST = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LAST = 4'(WR_WAIT - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       r_ub_n;
  logic       r_lb_n;

  logic       w_req;
  logic       w_mmio;
  logic       w_accept;
  logic       w_ld_hex;
  logic       w_ld_rd_sram;
  logic       w_ld_rd_sw;

  always_comb begin
    w_req        = ~Mem_CE & (~Mem_OE | ~Mem_WE);
    w_mmio       = (MAR == SW_ADDR);
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_accept     = 1'b0;
    w_ld_hex     = 1'b0;
    w_ld_rd_sram = 1'b0;
    w_ld_rd_sw   = 1'b0;
    mem_ready    = 1'b0;
    sram_ce_n    = 1'b1;
    sram_oe_n    = 1'b1;
    sram_we_n    = 1'b1;
    sram_ub_n    = 1'b1;
    sram_lb_n    = 1'b1;
    sram_dq_oe   = 1'b0;
    protocol_err = 1'b0;

    case (r_state)
      ST_IDLE: begin
        mem_ready = ~w_req;
        if (w_req) begin
          w_accept     = 1'b1;
          protocol_err = ~Mem_OE & ~Mem_WE & ~Reset;
          // A simultaneous read strobe is dropped in favour of the write.
          if (~Mem_WE) begin
            if (w_mmio) begin
              w_ld_hex    = 1'b1;
              w_state_nxt = ST_WR_HOLD;
            end else begin
              w_cnt_nxt   = WR_LAST;
              w_state_nxt = ST_WR_PULSE;
            end
          end else if (w_mmio) begin
            w_state_nxt = ST_MMIO_RD;
          end else begin
            w_cnt_nxt   = RD_LAST;
            w_state_nxt = ST_RD_WAIT;
          end
        end
      end

      ST_RD_WAIT: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_ub_n = r_ub_n;
        sram_lb_n = r_lb_n;
        if (r_cnt == 4'd0) begin
          w_ld_rd_sram = 1'b1;
          w_state_nxt  = ST_RD_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end

      ST_MMIO_RD: begin
        w_ld_rd_sw  = 1'b1;
        w_state_nxt = ST_RD_DONE;
      end

      ST_RD_DONE: begin
        mem_ready = 1'b1;
        if (Mem_OE) w_state_nxt = ST_IDLE;
      end

      // The pulse runs to its full length even if the CPU drops Mem_WE early.
      ST_WR_PULSE: begin
        sram_ce_n  = 1'b0;
        sram_we_n  = 1'b0;
        sram_ub_n  = r_ub_n;
        sram_lb_n  = r_lb_n;
        sram_dq_oe = 1'b1;
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_WR_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end

      ST_WR_HOLD: begin
        mem_ready = 1'b1;
        if (Mem_WE) w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sram_addr     <= 16'h0000;
      sram_wdata    <= 16'h0000;
      r_ub_n        <= 1'b1;
      r_lb_n        <= 1'b1;
      hex_out       <= 16'h0000;
      data_from_mem <= 16'h0000;
    end else begin
      if (w_accept) begin
        sram_addr <= MAR;
        r_ub_n    <= Mem_UB;
        r_lb_n    <= Mem_LB;
        if (~Mem_WE) sram_wdata <= data_to_mem;
      end
      if (w_ld_hex)     hex_out       <= data_to_mem;
      if (w_ld_rd_sram) data_from_mem <= sram_rdata;
      if (w_ld_rd_sw)   data_from_mem <= Switches;
    end
  end

endmodule

// File: tb/tb_slc3_mem_ctrl.sv
`timescale 1ns/1ps
// Bench for slc3_mem_ctrl: two instances (WR_WAIT 2 and 4) each backed by an SRAM model,
// driven by directed and random CPU transactions and scored against a word-level memory model.
module tb_slc3_mem_ctrl;

  localparam int RDW = 2;
  localparam logic [15:0] SW = 16'hFFFF;

  logic        Clk;
  logic        Reset;
  logic        Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB;
  logic [15:0] MAR, data_to_mem, Switches;
  int          sel;

  logic [15:0] data_from_mem [2];
  logic [15:0] hex_out       [2];
  logic [15:0] sram_addr     [2];
  logic [15:0] sram_wdata    [2];
  logic [15:0] sram_rdata    [2];
  logic        mem_ready     [2];
  logic        sram_dq_oe    [2];
  logic        sram_ce_n     [2];
  logic        sram_oe_n     [2];
  logic        sram_we_n     [2];
  logic        sram_ub_n     [2];
  logic        sram_lb_n     [2];
  logic        protocol_err  [2];

  int checks = 0;
  int failures = 0;

  // Expected state: word-addressed memory image and display register per instance.
  bit   [15:0] ref_mem [2][65536];
  bit          ref_v   [2][65536];
  logic [15:0] ref_hex [2];

  function automatic int wrw(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  // Power-up contents of the SRAM array.
  function automatic logic [15:0] pat(input logic [15:0] a);
    return (a == 16'h3000) ? 16'hBEEF : (a ^ 16'hC35A);
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic ub_n, input logic lb_n);
    logic [15:0] r;
    r = old;
    if (!ub_n) r[15:8] = d[15:8];
    if (!lb_n) r[7:0]  = d[7:0];
    return r;
  endfunction

  function automatic logic [15:0] ref_rd(input int k, input logic [15:0] a);
    return ref_v[k][a] ? ref_mem[k][a] : pat(a);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bit [15:0] phys [65536];
    bit        pv   [65536];

    slc3_mem_ctrl #(.RD_WAIT(RDW), .WR_WAIT(g == 0 ? 2 : 4), .SW_ADDR(SW)) u_dut (
      .Clk(Clk), .Reset(Reset),
      .Mem_CE(Mem_CE | (sel != g)), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
      .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
      .MAR(MAR), .data_to_mem(data_to_mem), .data_from_mem(data_from_mem[g]),
      .mem_ready(mem_ready[g]), .Switches(Switches), .hex_out(hex_out[g]),
      .sram_addr(sram_addr[g]), .sram_wdata(sram_wdata[g]), .sram_rdata(sram_rdata[g]),
      .sram_dq_oe(sram_dq_oe[g]), .sram_ce_n(sram_ce_n[g]), .sram_oe_n(sram_oe_n[g]),
      .sram_we_n(sram_we_n[g]), .sram_ub_n(sram_ub_n[g]), .sram_lb_n(sram_lb_n[g]),
      .protocol_err(protocol_err[g])
    );

    assign sram_rdata[g] = pv[sram_addr[g]] ? phys[sram_addr[g]] : pat(sram_addr[g]);

    // SRAM array: commits the byte-masked word mid-cycle while the write strobe is low.
    always @(negedge Clk) begin
      if (sram_ce_n[g] === 1'b0 && sram_we_n[g] === 1'b0) begin
        phys[sram_addr[g]] = merge(pv[sram_addr[g]] ? phys[sram_addr[g]] : pat(sram_addr[g]),
                                   sram_wdata[g], sram_ub_n[g], sram_lb_n[g]);
        pv[sram_addr[g]] = 1'b1;
      end
    end
  end

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_read(input logic [15:0] a, input logic ub, input logic lb);
    int cyc, oe_cnt, ce_cnt, hold;
    bit mmio;
    logic [15:0] exp;
    mmio = (a == SW);
    exp  = mmio ? Switches : ref_rd(sel, a);
    MAR = a; Mem_UB = ub; Mem_LB = lb; Mem_WE = 1'b1; Mem_OE = 1'b0; Mem_CE = 1'b0;
    #1;
    chk("rd_req_ready", mem_ready[sel], 1'b0);
    chk("rd_perr", protocol_err[sel], 1'b0);
    cyc = 0; oe_cnt = 0; ce_cnt = 0;
    while (cyc < 40) begin
      step();
      cyc++;
      if (sram_ce_n[sel] === 1'b0) ce_cnt++;
      if (sram_oe_n[sel] === 1'b0) begin
        oe_cnt++;
        chk("rd_sram_addr", sram_addr[sel], a);
        chk("rd_byte_en", {sram_ub_n[sel], sram_lb_n[sel]}, {ub, lb});
      end
      if (mem_ready[sel] === 1'b1) break;
    end
    chk("rd_latency", cyc, mmio ? 2 : RDW + 1);
    chk("rd_oe_cycles", oe_cnt, mmio ? 0 : RDW);
    chk("rd_ce_cycles", ce_cnt, mmio ? 0 : RDW);
    chk("rd_data", data_from_mem[sel], exp);
    hold = $urandom_range(0, 2);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("rd_hold_ready", mem_ready[sel], 1'b1);
      chk("rd_hold_data", data_from_mem[sel], exp);
    end
    Mem_OE = 1'b1; Mem_CE = 1'b1;
    step();
    chk("rd_release_ready", mem_ready[sel], 1'b1);
    chk("rd_data_kept", data_from_mem[sel], exp);
    chk("rd_hex_kept", hex_out[sel], ref_hex[sel]);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic ub,
                          input logic lb, input bit early, input bit both);
    int cyc, we_cnt, dq_cnt, ce_cnt, oe_cnt, pe_cnt;
    bit mmio;
    mmio = (a == SW);
    MAR = a; data_to_mem = d; Mem_UB = ub; Mem_LB = lb;
    Mem_OE = both ? 1'b0 : 1'b1; Mem_WE = 1'b0; Mem_CE = 1'b0;
    #1;
    chk("wr_req_ready", mem_ready[sel], 1'b0);
    chk("wr_perr_first", protocol_err[sel], both);
    cyc = 0; we_cnt = 0; dq_cnt = 0; ce_cnt = 0; oe_cnt = 0; pe_cnt = 0;
    while (cyc < 40) begin
      step();
      cyc++;
      if (sram_ce_n[sel] === 1'b0) ce_cnt++;
      if (sram_oe_n[sel] === 1'b0) oe_cnt++;
      if (sram_dq_oe[sel] === 1'b1) dq_cnt++;
      if (protocol_err[sel] === 1'b1) pe_cnt++;
      if (sram_we_n[sel] === 1'b0) begin
        we_cnt++;
        chk("wr_sram_addr", sram_addr[sel], a);
        chk("wr_sram_wdata", sram_wdata[sel], d);
        chk("wr_byte_en", {sram_ub_n[sel], sram_lb_n[sel]}, {ub, lb});
      end
      if (mem_ready[sel] === 1'b1) break;
      if (early && cyc == 1) begin
        Mem_WE = 1'b1; Mem_OE = 1'b1; Mem_CE = 1'b1; MAR = ~a; data_to_mem = ~d;
      end
    end
    chk("wr_latency", cyc, mmio ? 1 : wrw(sel) + 1);
    chk("wr_we_cycles", we_cnt, mmio ? 0 : wrw(sel));
    chk("wr_dq_cycles", dq_cnt, mmio ? 0 : wrw(sel));
    chk("wr_ce_cycles", ce_cnt, mmio ? 0 : wrw(sel));
    chk("wr_no_sram_read", oe_cnt, 0);
    chk("wr_perr_later", pe_cnt, 0);
    if (mmio) ref_hex[sel] = d;
    else begin
      ref_mem[sel][a] = merge(ref_rd(sel, a), d, ub, lb);
      ref_v[sel][a]   = 1'b1;
    end
    Mem_WE = 1'b1; Mem_OE = 1'b1; Mem_CE = 1'b1;
    step();
    chk("wr_release_ready", mem_ready[sel], 1'b1);
    chk("wr_hex", hex_out[sel], ref_hex[sel]);
  endtask

  initial begin
    int first_oe, rd_rdy, we_cnt, gap;
    int kind;
    logic [15:0] a;

    Reset = 1'b1; sel = 0;
    Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1; Mem_UB = 1'b0; Mem_LB = 1'b0;
    MAR = 16'h0; data_to_mem = 16'h0; Switches = 16'h0;
    ref_hex[0] = 16'h0; ref_hex[1] = 16'h0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_data", data_from_mem[k], 16'h0);
      chk("rst_hex", hex_out[k], 16'h0);
      chk("rst_addr", sram_addr[k], 16'h0);
      chk("rst_wdata", sram_wdata[k], 16'h0);
      chk("rst_strobes_n", {sram_ce_n[k], sram_oe_n[k], sram_we_n[k], sram_ub_n[k], sram_lb_n[k]}, 5'b11111);
      chk("rst_dq_oe", sram_dq_oe[k], 1'b0);
      chk("rst_perr", protocol_err[k], 1'b0);
      chk("rst_ready", mem_ready[k], 1'b1);
    end
    repeat (2) step();
    Reset = 1'b0;
    step();

    // Directed cases on the WR_WAIT=2 instance.
    do_read(16'h3000, 1'b0, 1'b0);
    do_write(16'h4000, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    do_read(16'h4000, 1'b0, 1'b0);
    Switches = 16'h0042;
    do_read(SW, 1'b0, 1'b0);
    do_write(SW, 16'h00A5, 1'b0, 1'b0, 1'b0, 1'b0);
    do_write(16'h4001, 16'h7777, 1'b0, 1'b0, 1'b0, 1'b1);
    do_read(16'h4001, 1'b0, 1'b0);

    // Reset landing in the middle of a read wait.
    MAR = 16'h3005; Mem_UB = 1'b0; Mem_LB = 1'b0; Mem_WE = 1'b1; Mem_OE = 1'b0; Mem_CE = 1'b0;
    #1;
    step();
    chk("rst_mid_pre_oe", sram_oe_n[0], 1'b0);
    Reset = 1'b1;
    #1;
    chk("rst_mid_strobes_n", {sram_ce_n[0], sram_oe_n[0]}, 2'b11);
    chk("rst_mid_data", data_from_mem[0], 16'h0);
    chk("rst_mid_hex", hex_out[0], 16'h0);
    chk("rst_mid_addr", sram_addr[0], 16'h0);
    Mem_OE = 1'b1; Mem_CE = 1'b1;
    #1;
    chk("rst_mid_ready", mem_ready[0], 1'b1);
    Reset = 1'b0;
    ref_hex[0] = 16'h0; ref_hex[1] = 16'h0;
    step();
    chk("rst_mid_idle_ready", mem_ready[0], 1'b1);

    // WR_WAIT=4: a read raised during the write pulse waits for the write to finish.
    sel = 1;
    MAR = 16'h3002; data_to_mem = 16'h5A5A; Mem_UB = 1'b0; Mem_LB = 1'b0;
    Mem_OE = 1'b1; Mem_WE = 1'b0; Mem_CE = 1'b0;
    #1;
    chk("defer_req_ready", mem_ready[1], 1'b0);
    first_oe = 0; rd_rdy = 0; we_cnt = 0;
    for (int c = 1; c <= 40 && rd_rdy == 0; c++) begin
      step();
      if (sram_we_n[1] === 1'b0) we_cnt++;
      if (sram_oe_n[1] === 1'b0 && first_oe == 0) first_oe = c;
      if (c <= wrw(1)) chk("defer_ready_low", mem_ready[1], 1'b0);
      if (first_oe != 0 && mem_ready[1] === 1'b1) rd_rdy = c;
      if (c == 1) begin
        Mem_WE = 1'b1; Mem_OE = 1'b0; MAR = 16'h3001;
      end
    end
    ref_mem[1][16'h3002] = 16'h5A5A; ref_v[1][16'h3002] = 1'b1;
    chk("defer_we_cycles", we_cnt, wrw(1));
    chk("defer_first_oe", first_oe, wrw(1) + 3);
    chk("defer_rd_latency", rd_rdy, wrw(1) + RDW + 3);
    chk("defer_rd_data", data_from_mem[1], ref_rd(1, 16'h3001));
    Mem_OE = 1'b1; Mem_CE = 1'b1;
    step();
    chk("defer_release_ready", mem_ready[1], 1'b1);
    do_read(16'h3002, 1'b0, 1'b0);

    // Random traffic on both instances over a small address window.
    for (int k = 0; k < 2; k++) begin
      sel = k;
      for (int n = 0; n < 30; n++) begin
        kind = $urandom_range(0, 9);
        a = 16'h3000 + 16'($urandom_range(0, 7));
        Switches = 16'($urandom);
        if (kind <= 3)
          do_read(a, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        else if (kind <= 7)
          do_write(a, 16'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
        else if (kind == 8)
          do_read(SW, 1'b0, 1'b0);
        else
          do_write(SW, 16'($urandom), 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        gap = $urandom_range(0, 2);
        for (int i = 0; i < gap; i++) begin
          step();
          chk("idle_ready", mem_ready[k], 1'b1);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
